sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Single-clock, fully parametrised FIFO for buffering bridge data within one clock domain. It is the successor to the dual-clock RX FIFO. Depth is now derived from ADDRBITS with no hard-coded pointer widths. It adds:
- an occupancy count
- programmable almost-full and almost-empty thresholds
- a selectable first-word-fall-through (FWFT) read mode
- synchronous flush
- sticky overflow and underflow error flags

Parameters:
WIDTH, 32, data word width in bits
ADDRBITS, 4, address width; DEPTH = 2**ADDRBITS entries
FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through
AF_LEVEL, 2**ADDRBITS-2, afull asserts when count >= AF_LEVEL
AE_LEVEL, 2, aempty asserts when count <= AE_LEVEL

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
wdata  input  WIDTH  write data
wen  input  1  write request
ren  input  1  read request
flush  input  1  synchronous discard of all contents
clr_err  input  1  clears the ovf and udf sticky flags
rdata  output  WIDTH  read data
eflag  output  1  empty (count == 0)
fflag  output  1  full (count == DEPTH)
afull  output  1  count >= AF_LEVEL
aempty  output  1  count <= AE_LEVEL
count  output  ADDRBITS+1  current occupancy, 0..DEPTH
ovf  output  1  sticky flag: a write was attempted while full
udf  output  1  sticky flag: a read was attempted while empty

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- Storage: DEPTH x WIDTH register array. Write and read pointers are ADDRBITS wide, in binary, and wrap from DEPTH-1 to 0. The count register is ADDRBITS+1 bits.
- Accept rules:
  - write accepted = wen & ~fflag
  - read accepted = ren & ~eflag
  - Both flags are evaluated from the registered state at the start of the cycle.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
  - When full, a simultaneous wen+ren accepts only the read. The write is dropped and ovf sets.
  - When empty, a simultaneous wen+ren accepts only the write. The read is dropped and udf sets.
- Count update: +1 on write only, -1 on read only, unchanged otherwise. Count never exceeds DEPTH and never underflows.
- Flag outputs: eflag, fflag, afull and aempty are combinational decodes of the registered count. They are valid in the same cycle the count updates, with no extra latency.
- FWFT=0 read path:
  - rdata is a register, loaded with mem[rptr] on the edge where the read is accepted, so data is valid the cycle after ren.
  - rdata holds its value when no read is accepted.
- FWFT=1 read path:
  - rdata = mem[rptr] continuously. It is valid whenever eflag=0, and ren pops the displayed word.
  - A word written into an empty FIFO appears on rdata the cycle after the write edge, when eflag falls.
- Flush:
  - Sets wptr, rptr and count to 0 in the next cycle.
  - Requests in the same cycle are ignored and do not set ovf or udf.
  - Memory contents and the FWFT=0 rdata register are unchanged.
  - ovf and udf are not cleared by flush.
- Sticky errors:
  - ovf sets on (wen & fflag); udf sets on (ren & eflag). Both hold until clr_err or reset.
  - If a set condition and clr_err occur in the same cycle, set wins.
- Priority: reset > flush > normal operation.
- Reset values: wptr = 0, rptr = 0, count = 0, rdata = 0 (FWFT=0), eflag = 1, fflag = 0, afull = 0 (for AF_LEVEL > 0), aempty = 1, ovf = 0, udf = 0. Memory is not reset.
- Reset mid-operation: all contents are discarded at the reset edge. Requests during reset are ignored and errors are not flagged.
- Parameter legality: AE_LEVEL < AF_LEVEL <= DEPTH, checked by an elaboration-time assertion.

Test Plan:
1. WIDTH=32, ADDRBITS=4, FWFT=0: write 0x00000001..0x00000010 (16 words).
   - fflag=1 and count=16 after the 16th edge.
   - afull asserts at count=14.
   - Read 16 words: rdata sequence 1..16, each one cycle after ren; eflag=1 at the end.
2. Wrap-around: write 10, read 10, write 12, read 12.
   - Data order is preserved across the pointer wrap, with count tracking 0→10→0→12→0.
3. With the FIFO full, assert wen+ren together.
   - The read is accepted, count becomes 15, and ovf=1.
   - With the FIFO empty, wen+ren together: count becomes 1 and udf=1.
   - Pulse clr_err: both flags return to 0.
4. FWFT=1, from empty: write 0xDEADBEEF.
   - The next cycle shows eflag=0 and rdata=0xDEADBEEF before any ren.
   - ren pops it, and eflag=1 the following cycle.
5. Load 7 words, then assert flush with wen=1.
   - Next cycle: count=0, eflag=1, the write is not stored, and ovf/udf are unchanged.
6. Load 9 words, then assert reset for one cycle with wen=1 and ren=1.
   - All outputs show their reset values and count=0.
   - Subsequent operation is normal from an empty state.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO: occupancy count, almost-full/empty thresholds,
// optional first-word-fall-through read, synchronous flush and sticky error flags.

module sync_fifo_param_chk #(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) ();
    generate
        if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
            $error("sync_fifo_param: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate
endmodule

module sync_fifo_param #(
    parameter int WIDTH    = 32,
    parameter int ADDRBITS = 4,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 2**ADDRBITS - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    wdata,
    input  logic                wen,
    input  logic                ren,
    input  logic                flush,
    input  logic                clr_err,
    output logic [WIDTH-1:0]    rdata,
    output logic                eflag,
    output logic                fflag,
    output logic                afull,
    output logic                aempty,
    output logic [ADDRBITS:0]   count,
    output logic                ovf,
    output logic                udf
);
    localparam int DEPTH = 2**ADDRBITS;

    localparam logic [ADDRBITS:0]   DEPTH_C  = (ADDRBITS+1)'(DEPTH);
    localparam logic [ADDRBITS:0]   AF_C     = (ADDRBITS+1)'(AF_LEVEL);
    localparam logic [ADDRBITS:0]   AE_C     = (ADDRBITS+1)'(AE_LEVEL);
    localparam logic [ADDRBITS:0]   CNT_ZERO = (ADDRBITS+1)'(1'b0);
    localparam logic [ADDRBITS:0]   CNT_ONE  = (ADDRBITS+1)'(1'b1);
    localparam logic [ADDRBITS-1:0] PTR_ZERO = ADDRBITS'(1'b0);
    localparam logic [ADDRBITS-1:0] PTR_ONE  = ADDRBITS'(1'b1);

    sync_fifo_param_chk #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_chk ();

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [ADDRBITS-1:0] wptr_q, wptr_d;
    logic [ADDRBITS-1:0] rptr_q, rptr_d;
    logic [ADDRBITS:0]   count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                eflag_s, fflag_s, afull_s, aempty_s;
    logic                wr_acc_s, rd_acc_s, ovf_set_s, udf_set_s;

    // Status flags decoded straight from the registered occupancy.
    always_comb begin
        eflag_s  = (count_q == CNT_ZERO);
        fflag_s  = (count_q == DEPTH_C);
        afull_s  = (count_q >= AF_C);
        aempty_s = (count_q <= AE_C);
    end

    // Request acceptance, pointer/count next state and sticky error next state.
    always_comb begin
        wr_acc_s  = 1'b0;
        rd_acc_s  = 1'b0;
        ovf_set_s = 1'b0;
        udf_set_s = 1'b0;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (flush) begin
            wptr_d  = PTR_ZERO;
            rptr_d  = PTR_ZERO;
            count_d = CNT_ZERO;
        end else begin
            // Full/empty come from the start-of-cycle count, so a full FIFO
            // still takes a read and an empty one still takes a write.
            wr_acc_s  = wen & ~fflag_s;
            rd_acc_s  = ren & ~eflag_s;
            ovf_set_s = wen & fflag_s;
            udf_set_s = ren & eflag_s;
            if (wr_acc_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_acc_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (udf_set_s) begin
            udf_d = 1'b1;
        end else if (clr_err) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // Pointer, occupancy and error-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= PTR_ZERO;
            rptr_q  <= PTR_ZERO;
            count_q <= CNT_ZERO;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !reset) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = mem_q[rptr_q];
        end else begin : g_reg_read
            logic [WIDTH-1:0] rdata_q, rdata_d;

            // Load the head word only on an accepted read, otherwise hold.
            always_comb begin
                if (rd_acc_s) begin
                    rdata_d = mem_q[rptr_q];
                end else begin
                    rdata_d = rdata_q;
                end
            end

            // Registered read data.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q <= {WIDTH{1'b0}};
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

    assign eflag  = eflag_s;
    assign fflag  = fflag_s;
    assign afull  = afull_s;
    assign aempty = aempty_s;
    assign count  = count_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read and an FWFT instance share stimulus,
// a queue scoreboard predicts data, occupancy and sticky flags.

module tb_sync_fifo_param;
    logic        clk;
    logic        reset, wen, ren, flush, clr_err;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1;
    logic        eflag0, fflag0, afull0, aempty0, ovf0, udf0;
    logic        eflag1, fflag1, afull1, aempty1, ovf1, udf1;
    logic [4:0]  count0, count1;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb [$];
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    sync_fifo_param #(.WIDTH(32), .ADDRBITS(4), .FWFT(0)) dut0 (
        .clk(clk), .reset(reset), .wdata(wdata), .wen(wen), .ren(ren),
        .flush(flush), .clr_err(clr_err), .rdata(rdata0), .eflag(eflag0),
        .fflag(fflag0), .afull(afull0), .aempty(aempty0), .count(count0),
        .ovf(ovf0), .udf(udf0));

    sync_fifo_param #(.WIDTH(32), .ADDRBITS(4), .FWFT(1)) dut1 (
        .clk(clk), .reset(reset), .wdata(wdata), .wen(wen), .ren(ren),
        .flush(flush), .clr_err(clr_err), .rdata(rdata1), .eflag(eflag1),
        .fflag(fflag1), .afull(afull1), .aempty(aempty1), .count(count1),
        .ovf(ovf1), .udf(udf1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of requests, clock it, update the scoreboard, settle 1ns.
    task automatic tick(input logic w, input logic r, input logic fl,
                        input logic clr, input logic rst, input logic [31:0] d);
        logic wacc, racc, so, su;
        wen = w; ren = r; flush = fl; clr_err = clr; reset = rst; wdata = d;
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 32'h0;
        end else begin
            wacc = !fl && w && (m_cnt != 16);
            racc = !fl && r && (m_cnt != 0);
            so   = !fl && w && (m_cnt == 16);
            su   = !fl && r && (m_cnt == 0);
            if (fl) begin
                sb.delete();
                m_cnt = 0;
            end
            if (racc) begin
                m_rdata = sb.pop_front();
                m_cnt   = m_cnt - 1;
            end
            if (wacc) begin
                sb.push_back(d);
                m_cnt = m_cnt + 1;
            end
            if (so) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
            if (su) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
        end
        #1;
        wen = 1'b0; ren = 1'b0; flush = 1'b0; clr_err = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (count0 !== 5'd0 || eflag0 !== 1'b1 || fflag0 !== 1'b0 || afull0 !== 1'b0 || aempty0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got cnt=%0d e=%b f=%b af=%b ae=%b, expected cnt=0 e=1 f=0 af=0 ae=1",
                     count0, eflag0, fflag0, afull0, aempty0);
        end
        checks++;
        if (ovf0 !== 1'b0 || udf0 !== 1'b0 || rdata0 !== 32'h0 || count1 !== 5'd0 || eflag1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_misc: got ovf=%b udf=%b rdata=%h cnt1=%0d e1=%b, expected 0 0 00000000 0 1",
                     ovf0, udf0, rdata0, count1, eflag1);
        end
    endtask

    task automatic test_fill_drain();
        logic exp_b;
        for (int i = 1; i <= 16; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'(i));
            checks++;
            if (count0 !== 5'(i)) begin
                errors++;
                $display("FAIL fill_count: got %0d expected %0d", count0, i);
            end
            exp_b = (i >= 14);
            checks++;
            if (afull0 !== exp_b) begin
                errors++;
                $display("FAIL fill_afull: count=%0d got %b expected %b", i, afull0, exp_b);
            end
        end
        checks++;
        if (fflag0 !== 1'b1 || eflag0 !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got f=%b e=%b expected f=1 e=0", fflag0, eflag0);
        end
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (rdata0 !== m_rdata || rdata0 !== 32'(i)) begin
                errors++;
                $display("FAIL drain_rdata: got %h expected %h", rdata0, 32'(i));
            end
            exp_b = ((16 - i) <= 2);
            checks++;
            if (count0 !== 5'(16 - i) || aempty0 !== exp_b) begin
                errors++;
                $display("FAIL drain_count: got cnt=%0d ae=%b expected cnt=%0d ae=%b", count0, aempty0, 16 - i, exp_b);
            end
        end
        checks++;
        if (eflag0 !== 1'b1 || fflag0 !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got e=%b f=%b expected e=1 f=0", eflag0, fflag0);
        end
    endtask

    task automatic test_wrap();
        int lens [4] = '{10, 10, 12, 12};
        int exp_cnt [4] = '{10, 0, 12, 0};
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < lens[p]; k++) begin
                if (p % 2 == 0) begin
                    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
                end else begin
                    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
                    checks++;
                    if (rdata0 !== m_rdata) begin
                        errors++;
                        $display("FAIL wrap_rdata: phase %0d got %h expected %h", p, rdata0, m_rdata);
                    end
                end
            end
            checks++;
            if (count0 !== 5'(exp_cnt[p]) || count1 !== 5'(exp_cnt[p])) begin
                errors++;
                $display("FAIL wrap_count: phase %0d got %0d/%0d expected %0d", p, count0, count1, exp_cnt[p]);
            end
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA000_0000 + 32'(i));
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hBAD0_BAD0);
        checks++;
        if (count0 !== 5'd15 || ovf0 !== 1'b1 || udf0 !== 1'b0 || rdata0 !== 32'hA000_0000) begin
            errors++;
            $display("FAIL full_wr_rd: got cnt=%0d ovf=%b udf=%b rdata=%h expected 15 1 0 a0000000",
                     count0, ovf0, udf0, rdata0);
        end
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (rdata0 !== m_rdata) begin
                errors++;
                $display("FAIL err_drain: got %h expected %h", rdata0, m_rdata);
            end
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0055);
        checks++;
        if (count0 !== 5'd1 || udf0 !== 1'b1 || ovf0 !== 1'b1 || rdata1 !== 32'h0000_0055) begin
            errors++;
            $display("FAIL empty_wr_rd: got cnt=%0d udf=%b ovf=%b rdata1=%h expected 1 1 1 00000055",
                     count0, udf0, ovf0, rdata1);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (ovf0 !== 1'b0 || udf0 !== 1'b0 || ovf1 !== 1'b0 || udf1 !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: got ovf=%b udf=%b expected 0 0", ovf0, udf0);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (udf0 !== m_udf || udf0 !== 1'b1 || count0 !== 5'd0) begin
            errors++;
            $display("FAIL set_wins: got udf=%b cnt=%0d expected udf=1 cnt=0", udf0, count0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_fwft();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        checks++;
        if (eflag1 !== 1'b0 || rdata1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL fwft_show: got e=%b rdata=%h expected e=0 rdata=deadbeef", eflag1, rdata1);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (eflag1 !== 1'b1 || count1 !== 5'd0 || rdata0 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL fwft_pop: got e1=%b cnt1=%0d rdata0=%h expected 1 0 deadbeef", eflag1, count1, rdata0);
        end
    endtask

    task automatic test_flush();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7000_0000 + 32'(i));
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7777_7777);
        checks++;
        if (count0 !== 5'd0 || eflag0 !== 1'b1 || eflag1 !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: got cnt=%0d e0=%b e1=%b expected 0 1 1", count0, eflag0, eflag1);
        end
        checks++;
        if (udf0 !== m_udf || udf0 !== 1'b1 || ovf0 !== 1'b0 || rdata0 !== m_rdata) begin
            errors++;
            $display("FAIL flush_keep: got udf=%b ovf=%b rdata=%h expected 1 0 %h", udf0, ovf0, rdata0, m_rdata);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001);
        checks++;
        if (count0 !== 5'd1 || rdata1 !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL flush_after_wr: got cnt=%0d rdata1=%h expected 1 cafe0001", count0, rdata1);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (rdata0 !== 32'hCAFE_0001 || eflag0 !== 1'b1) begin
            errors++;
            $display("FAIL flush_after_rd: got rdata=%h e=%b expected cafe0001 1", rdata0, eflag0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h9000_0000 + 32'(i));
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        checks++;
        if (count0 !== 5'd0 || eflag0 !== 1'b1 || fflag0 !== 1'b0 || afull0 !== 1'b0 || aempty0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_status: got cnt=%0d e=%b f=%b af=%b ae=%b expected 0 1 0 0 1",
                     count0, eflag0, fflag0, afull0, aempty0);
        end
        checks++;
        if (ovf0 !== 1'b0 || udf0 !== 1'b0 || rdata0 !== 32'h0 || count1 !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid_misc: got ovf=%b udf=%b rdata=%h cnt1=%0d expected 0 0 00000000 0",
                     ovf0, udf0, rdata0, count1);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3300_0000 + 32'(i));
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (rdata0 !== m_rdata || rdata0 !== 32'h3300_0000 + 32'(i)) begin
                errors++;
                $display("FAIL rst_mid_after: got %h expected %h", rdata0, 32'h3300_0000 + 32'(i));
            end
        end
        checks++;
        if (eflag0 !== 1'b1 || udf0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_end: got e=%b udf=%b expected 1 0", eflag0, udf0);
        end
    endtask

    initial begin
        reset = 1'b1; wen = 1'b0; ren = 1'b0; flush = 1'b0; clr_err = 1'b0; wdata = 32'h0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_errors();
        test_fwft();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
